// File: rtl/sc_bs2bin_acc.sv
// ---------------------------------------------------------------------------
// sc_bs2bin_acc
// Stochastic-to-binary converter. It counts the 1s of a unipolar bitstream
// over a window of 2^DATAWD samples. It then presents the saturated count as
// a DATAWD-bit value behind a valid/ready handshake.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous, active-low reset
//   iStart  in   request to begin a conversion window (sampled in IDLE/DONE)
//   iBit    in   stochastic bitstream, sampled every cycle while in RUN
//   iReady  in   downstream accepts the result
//   oBusy   out  high while a window is being accumulated
//   oValid  out  result available, held until accepted
//   oData   out  min(count of 1s, 2^DATAWD-1)
// ---------------------------------------------------------------------------
module sc_bs2bin_acc #(
  parameter int DATAWD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iStart,
  input  logic              iBit,
  input  logic              iReady,
  output logic              oBusy,
  output logic              oValid,
  output logic [DATAWD-1:0] oData
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // The count can reach exactly 2^DATAWD (all-ones window), hence one extra bit.
  logic [DATAWD:0]   ones_q;
  logic [DATAWD:0]   ones_sum;
  logic [DATAWD-1:0] cyc_q;

  logic clr;
  logic acc_en;
  logic load;

  assign ones_sum = ones_q + {{DATAWD{1'b0}}, iBit};

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    acc_en  = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        clr = 1'b1;
        if (iStart) state_d = S_RUN;
      end
      S_RUN: begin
        acc_en = 1'b1;
        // Last sample of the window: the cycle counter is about to wrap.
        if (cyc_q == {DATAWD{1'b1}}) begin
          load    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Only a completed transfer may leave DONE; iStart alone is ignored.
        if (iReady) begin
          if (iStart) begin
            state_d = S_RUN;
            clr     = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ones_q  <= '0;
      cyc_q   <= '0;
      oBusy   <= 1'b0;
      oValid  <= 1'b0;
      oData   <= '0;
    end else begin
      state_q <= state_d;
      // Busy/valid are registered copies of the next state, so they line up
      // with the state register and have no combinational input path.
      oBusy   <= (state_d == S_RUN);
      oValid  <= (state_d == S_DONE);

      if (clr) begin
        ones_q <= '0;
        cyc_q  <= '0;
      end else if (acc_en) begin
        ones_q <= ones_sum;
        cyc_q  <= cyc_q + DATAWD'(1);
      end

      // Saturate: the only value with the top bit set is exactly 2^DATAWD.
      if (load) begin
        oData <= ones_sum[DATAWD] ? {DATAWD{1'b1}} : ones_sum[DATAWD-1:0];
      end
    end
  end

endmodule

// File: tb/tb_sc_bs2bin_acc.sv
// ---------------------------------------------------------------------------
// tb_sc_bs2bin_acc
// Self-checking bench for sc_bs2bin_acc. A DATAWD=4 instance covers reset,
// saturation, fixed patterns, backpressure, back-to-back windows and random
// windows. A DATAWD=8 instance is fed an AND-gate product of two stochastic
// streams. Expected values come from counting the driven bits and saturating.
// ---------------------------------------------------------------------------
module tb_sc_bs2bin_acc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // DATAWD = 4 instance
  logic       start4 = 1'b0, bit4 = 1'b0, ready4 = 1'b0;
  logic       busy4, valid4;
  logic [3:0] data4;

  // DATAWD = 8 instance
  logic       start8 = 1'b0, bit8 = 1'b0, ready8 = 1'b0;
  logic       busy8, valid8;
  logic [7:0] data8;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t_done   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sc_bs2bin_acc #(.DATAWD(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .iStart(start4), .iBit(bit4), .iReady(ready4),
    .oBusy(busy4), .oValid(valid4), .oData(data4)
  );

  sc_bs2bin_acc #(.DATAWD(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .iStart(start8), .iBit(bit8), .iReady(ready8),
    .oBusy(busy8), .oValid(valid8), .oData(data8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: count the 1s of a window, saturate at 2^w - 1.
  function automatic int model_count(input logic [255:0] bits, input int n, input int w);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(bits[i]);
    return (s > (1 << w) - 1) ? (1 << w) - 1 : s;
  endfunction

  // Accept iStart in IDLE (edge T). Returns just after T.
  task automatic start_w4();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  // Called just after edge T; drives 16 samples, checks busy for exactly 16
  // cycles, then checks DONE outputs at edge T+16.
  task automatic feed_w4(input string tag, input logic [15:0] pat);
    int busy_cycles = 0;
    int exp_data;
    exp_data = model_count({240'd0, pat}, 16, 4);
    for (int i = 0; i < 16; i++) begin
      bit4 = pat[i];
      if (busy4 === 1'b1) busy_cycles++;
      if (valid4 !== 1'b0) check({tag, "_early_valid"}, {31'd0, valid4}, 32'd0);
      tick();
    end
    bit4 = 1'b0;
    t_done = cyc;
    check({tag, "_busy_cycles"}, busy_cycles, 16);
    check({tag, "_valid"}, {31'd0, valid4}, 32'd1);
    check({tag, "_busy_off"}, {31'd0, busy4}, 32'd0);
    check({tag, "_data"}, {28'd0, data4}, exp_data);
  endtask

  task automatic accept_w4(input string tag);
    ready4 = 1'b1;
    tick();
    ready4 = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, valid4}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy4}, 32'd0);
  endtask

  // AND-gate multiplier: A from a unary counter compare, B from a
  // bit-reversed counter compare, so the two streams are decorrelated.
  task automatic chain_w8(input string tag, input int a, input int b, input int tol_lo,
                          input int tol_hi);
    logic [255:0] bits = '0;
    logic [7:0]   idx;
    logic [7:0]   rev;
    int           exp_data;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check({tag, "_busy"}, {31'd0, busy8}, 32'd1);
    for (int i = 0; i < 256; i++) begin
      idx = 8'(i);
      rev = {<<{idx}};
      bits[i] = (i < a) && (int'(rev) < b);
      bit8 = bits[i];
      tick();
    end
    bit8 = 1'b0;
    exp_data = model_count(bits, 256, 8);
    check({tag, "_valid"}, {31'd0, valid8}, 32'd1);
    check({tag, "_data"}, {24'd0, data8}, exp_data);
    check({tag, "_tol"}, {31'd0, (int'(data8) >= tol_lo) && (int'(data8) <= tol_hi)}, 32'd1);
    ready8 = 1'b1;
    tick();
    ready8 = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, valid8}, 32'd0);
  endtask

  initial begin
    logic [15:0] held;
    int t_first;

    // ---- reset state ----
    #12;
    check("rst_busy", {31'd0, busy4}, 32'd0);
    check("rst_valid", {31'd0, valid4}, 32'd0);
    check("rst_data", {28'd0, data4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---- known pattern 1,0,1,0... -> 8 ----
    start_w4();
    feed_w4("alt", 16'h5555);
    accept_w4("alt");

    // ---- reset mid-RUN after 7 ones ----
    start_w4();
    for (int i = 0; i < 7; i++) begin
      bit4 = 1'b1;
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy4}, 32'd0);
    check("midrst_valid", {31'd0, valid4}, 32'd0);
    check("midrst_data", {28'd0, data4}, 32'd0);
    bit4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_w4();
    feed_w4("zeros", 16'h0000);
    accept_w4("zeros");

    // ---- full scale: saturates to 15 ----
    start_w4();
    check("full_busy_start", {31'd0, busy4}, 32'd1);
    t_first = cyc;
    feed_w4("full", 16'hFFFF);
    check("full_latency", t_done - t_first, 16);
    accept_w4("full");

    // ---- five ones then zeros -> 5 ----
    start_w4();
    feed_w4("five", 16'h001F);

    // ---- backpressure: iReady low, iStart/iBit toggling ----
    held = 16'd5;
    for (int i = 0; i < 10; i++) begin
      start4 = 1'($urandom_range(0, 1));
      bit4   = 1'($urandom_range(0, 1));
      tick();
      check("bp_valid", {31'd0, valid4}, 32'd1);
      check("bp_busy", {31'd0, busy4}, 32'd0);
      check("bp_data", {28'd0, data4}, {16'd0, held});
    end
    start4 = 1'b0;
    bit4   = 1'b0;
    accept_w4("bp");

    // ---- back-to-back windows ----
    start_w4();
    feed_w4("b2b1", 16'h0F0F);
    t_first = t_done;
    ready4 = 1'b1;
    start4 = 1'b1;
    tick();
    ready4 = 1'b0;
    start4 = 1'b0;
    check("b2b_busy", {31'd0, busy4}, 32'd1);
    check("b2b_valid", {31'd0, valid4}, 32'd0);
    feed_w4("b2b2", 16'h0301);
    check("b2b_spacing", t_done - t_first, 17);
    accept_w4("b2b2");

    // ---- random windows ----
    for (int r = 0; r < 6; r++) begin
      logic [15:0] pat;
      pat = 16'($urandom);
      if (r == 2) pat = pat | 16'hFFF0;
      start_w4();
      feed_w4("rand", pat);
      accept_w4("rand");
    end

    // ---- multiplier chain, DATAWD = 8 ----
    chain_w8("mul_half", 128, 128, 62, 66);
    chain_w8("mul_zero", 255, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_bs2bin_acc.md
# sc_bs2bin_acc

Stochastic-to-binary converter for the unipolar SC datapath. It counts the 1s of a bitstream, such as the `oC` output of the AND-gate stochastic multiplier, over a fixed window of 2^DATAWD cycles. It then presents the count as a DATAWD-bit binary value with a valid/ready handshake. It sits directly downstream of the SC arithmetic units and closes the binary-to-stochastic-to-binary loop for test and accuracy measurement.

## Interface
- DATAWD, default 8 (matches `INWD`): output width; the window is 2^DATAWD cycles.
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- iStart  input  1  request to begin a conversion window.
- iBit  input  1  stochastic bitstream, sampled every cycle while in RUN.
- iReady  input  1  downstream accepts the result.
- oBusy  output  1  high while in RUN.
- oValid  output  1  result available; high while in DONE.
- oData  output  DATAWD  converted value, saturated count of 1s.

## Operation
- FSM states: IDLE, RUN, DONE. The reset state is IDLE.
- Reset values: oBusy=0, oValid=0, oData=0, 1s counter=0, cycle counter=0.
- IDLE:
  - iStart=1 → RUN.
  - Clear the 1s counter and the cycle counter.
- RUN:
  - On each rising edge, add iBit to the 1s counter (DATAWD+1 bits wide).
  - On each rising edge, increment the cycle counter (DATAWD bits wide).
  - When the cycle counter wraps from 2^DATAWD−1 to 0 (the 2^DATAWD-th sample), load oData and go to DONE.
  - iStart is ignored in RUN.
- Saturation:
  - oData = min(count, 2^DATAWD−1).
  - An all-ones window gives count 2^DATAWD, so oData = all ones.
  - No other scaling applies: oData/2^DATAWD estimates P(iBit=1).
- DONE:
  - oValid=1 and oData is held stable until the transfer (oValid & iReady) occurs.
  - Transfer with iStart=0 → IDLE.
  - Transfer with iStart=1 → RUN directly (back-to-back window); both counters are cleared.
  - iStart without iReady is ignored. No result is ever overwritten before it is accepted.
- oData keeps its last value in IDLE and RUN. It changes only on entry to DONE.
- Reset mid-operation: any state returns to IDLE immediately. The partial count is discarded and all outputs go to their reset values.

## Timing
- iStart sampled high at edge T (IDLE):
  - oBusy=1 from T until edge T+2^DATAWD.
  - iBit is sampled at edges T+1 … T+2^DATAWD, exactly 2^DATAWD samples.
- At edge T+2^DATAWD:
  - State becomes DONE; oValid=1 and oData are valid in the same cycle.
  - oBusy=0.
- Latency from iStart to oValid: 2^DATAWD cycles.
- Handshake: transfer at the edge where oValid & iReady. oValid drops after that edge unless a back-to-back start was taken; in that case oBusy=1 next cycle.
- Back-to-back throughput: one result per 2^DATAWD+1 cycles. The DONE cycle is never skipped.
- All outputs are registered. There is no combinational path from an input to an output.
- Upstream operands must be loaded, and must hold, before the edge where iStart is accepted. This block issues no load strobes.

## Test plan
- **Reset:** DATAWD=4; assert rst_n=0 mid-RUN after 7 samples of iBit=1 → oBusy=0, oValid=0, oData=0. Then start with iBit=0 for 16 cycles → oData=0.
- **Full scale:** iBit=1 constant, iStart pulse → oValid rises exactly 16 cycles after start; oData=15 (saturated); oBusy high for exactly 16 cycles.
- **Known pattern:** iBit = 1,0,1,0… over 16 cycles → oData=8. Also drive 5 ones at cycles 1–5, then 0s → oData=5.
- **Backpressure:** hold iReady=0 for 10 cycles after oValid and toggle iStart and iBit → oValid stays high, oData stays unchanged, no new RUN. Then iReady=1 → oValid drops on the next edge.
- **Back-to-back:** iReady=1 and iStart=1 in DONE → RUN next cycle; the second result equals the second window's count. Results arrive 17 cycles apart.
- **Multiplier chain:** feed `oC` from the multiplier with iA=iB=128, DATAWD=8 → oData=64 ±2 (Sobol correlation tolerance). iA=255, iB=0 → oData=0.
